writeback_gather_stage: RTL

Parametrised writeback stage for the vector pipeline. Aligns and sign-extends sub-word memory reads, selects between load data and ALU result, and drives the registered register-file commit controls. It also accumulates multi-cycle gather loads, one lane per beat, into a vector buffer. A gather commits with a single writeback once its last lane arrives. It sits between the memory-access stage and the register file.

---
 rtl/writeback_gather_stage.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/writeback_gather_stage.sv
// writeback_gather_stage: sub-word load alignment, ALU/load select and
// registered register-file commit, plus a one-lane-per-beat gather buffer.
//
// Ports:
//   clk, reset_n               clock, async active-low reset
//   valid_i                    instruction present this cycle
//   instruction_i              instruction word (load decode + width field)
//   writeback_reg_i            destination register
//   writeback_is_vector_i      destination is a vector register
//   has_writeback_i            instruction writes a register
//   mask_i                     lane mask, bit NUM_LANES-1 is lane 0
//   result_i                   ALU result / addresses, lane 0 in the MSBs
//   ddata_i                    memory read word, byte 0 in the MSBs
//   lane_select_i              lane targeted by a load beat
//   gather_i, gather_last_i    gather beat / final gather beat
//   writeback_is_vector_o      commit: vector destination
//   has_writeback_o            commit strobe
//   writeback_reg_o            commit register
//   writeback_value_o          commit data
//   mask_o                     commit lane mask
//   gather_busy_o              gather partially collected
//   gather_abort_o             one-cycle pulse on a discarded gather

module writeback_gather_stage #(
    parameter int NUM_LANES = 16,
    parameter int LANE_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      valid_i,
    input  logic [31:0]               instruction_i,
    input  logic [4:0]                writeback_reg_i,
    input  logic                      writeback_is_vector_i,
    input  logic                      has_writeback_i,
    input  logic [NUM_LANES-1:0]      mask_i,
    input  logic [32*NUM_LANES-1:0]   result_i,
    input  logic [31:0]               ddata_i,
    input  logic [LANE_W-1:0]         lane_select_i,
    input  logic                      gather_i,
    input  logic                      gather_last_i,
    output logic                      writeback_is_vector_o,
    output logic                      has_writeback_o,
    output logic [4:0]                writeback_reg_o,
    output logic [32*NUM_LANES-1:0]   writeback_value_o,
    output logic [NUM_LANES-1:0]      mask_o,
    output logic                      gather_busy_o,
    output logic                      gather_abort_o
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t state;

    logic [31:0]          buf_q [NUM_LANES];
    logic [NUM_LANES-1:0] acc_mask_q;

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    logic [3:0] width;
    logic       is_load;
    logic       w_ub;
    logic       w_sb;
    logic       w_uh;
    logic       w_sh;

    assign width   = instruction_i[28:25];
    // Width 0110 is the control-register transfer form, not a memory read.
    assign is_load = (instruction_i[31:30] == 2'b10)
                   && instruction_i[29]
                   && (width != 4'b0110);

    assign w_ub = (width == 4'b0000);
    assign w_sb = (width == 4'b0001);
    assign w_uh = (width == 4'b0010);
    assign w_sh = (width == 4'b0011);

    // Remaining instruction bits do not affect writeback.
    logic unused_instr;
    assign unused_instr = ^instruction_i[24:0];

    // ---------------------------------------------------------------
    // Address source
    // ---------------------------------------------------------------
    logic [1:0] lane_addr [NUM_LANES];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_addr
        assign lane_addr[g] = result_i[32*(NUM_LANES-g)-32 +: 2];
    end

    logic [1:0] addr;
    assign addr = gather_i ? lane_addr[lane_select_i]
                           : result_i[1:0];

    // ---------------------------------------------------------------
    // Alignment and extension
    // ---------------------------------------------------------------
    logic [7:0]  bytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] aligned;

    assign bytes[0] = ddata_i[31:24];
    assign bytes[1] = ddata_i[23:16];
    assign bytes[2] = ddata_i[15:8];
    assign bytes[3] = ddata_i[7:0];

    assign byte_sel = bytes[addr];
    assign half_sel = addr[1] ? {bytes[3], bytes[2]}
                              : {bytes[1], bytes[0]};

    always_comb begin
        aligned = '0;
        unique case (1'b1)
            w_ub: aligned = {24'h0, byte_sel};
            w_sb: aligned = {{24{byte_sel[7]}}, byte_sel};
            w_uh: aligned = {16'h0, half_sel};
            w_sh: aligned = {{16{half_sel[15]}}, half_sel};
            default: aligned = {bytes[3], bytes[2],
                                bytes[1], bytes[0]};
        endcase
    end

    // ---------------------------------------------------------------
    // Lane mask for the targeted lane
    // ---------------------------------------------------------------
    // Lane 0 is the mask MSB; with a power-of-two lane count the
    // reversed index NUM_LANES-1-lane is simply the bitwise inverse.
    logic [LANE_W-1:0]    lane_rev;
    logic [NUM_LANES-1:0] lane_onehot;
    logic [NUM_LANES-1:0] cur_bit;

    assign lane_rev = ~lane_select_i;

    always_comb begin
        lane_onehot           = '0;
        lane_onehot[lane_rev] = 1'b1;
    end

    assign cur_bit = lane_onehot & mask_i;

    // ---------------------------------------------------------------
    // Commit data candidates
    // ---------------------------------------------------------------
    logic [32*NUM_LANES-1:0] merged;
    logic [32*NUM_LANES-1:0] ng_value;
    logic [NUM_LANES-1:0]    ng_mask;

    // The last beat lands in the same cycle as the commit, so the
    // current lane bypasses the buffer.
    always_comb begin
        merged = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_select_i == LANE_W'(i))
                merged[32*(NUM_LANES-i)-1 -: 32] = aligned;
            else
                merged[32*(NUM_LANES-i)-1 -: 32] = buf_q[i];
        end
    end

    assign ng_value = is_load ? {NUM_LANES{aligned}} : result_i;
    assign ng_mask  = is_load ? cur_bit : mask_i;

    // ---------------------------------------------------------------
    // FSM, buffer and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            acc_mask_q            <= '0;
            for (int i = 0; i < NUM_LANES; i++)
                buf_q[i] <= '0;
            writeback_is_vector_o <= 1'b0;
            has_writeback_o       <= 1'b0;
            writeback_reg_o       <= '0;
            writeback_value_o     <= '0;
            mask_o                <= '0;
            gather_abort_o        <= 1'b0;
        end else begin
            gather_abort_o <= 1'b0;
            if (!valid_i) begin
                has_writeback_o <= 1'b0;
            end else if (gather_i) begin
                if (gather_last_i) begin
                    has_writeback_o       <= has_writeback_i;
                    writeback_reg_o       <= writeback_reg_i;
                    writeback_is_vector_o <= writeback_is_vector_i;
                    writeback_value_o     <= merged;
                    mask_o                <= acc_mask_q | cur_bit;
                    acc_mask_q            <= '0;
                    for (int i = 0; i < NUM_LANES; i++)
                        buf_q[i] <= '0;
                    state <= IDLE;
                end else begin
                    has_writeback_o       <= 1'b0;
                    buf_q[lane_select_i]  <= aligned;
                    acc_mask_q            <= acc_mask_q | cur_bit;
                    state                 <= COLLECT;
                end
            end else begin
                // A plain instruction during a gather discards it
                // and is still committed in the same cycle.
                if (state == COLLECT) begin
                    gather_abort_o <= 1'b1;
                    acc_mask_q     <= '0;
                    for (int i = 0; i < NUM_LANES; i++)
                        buf_q[i] <= '0;
                    state <= IDLE;
                end
                has_writeback_o       <= has_writeback_i;
                writeback_reg_o       <= writeback_reg_i;
                writeback_is_vector_o <= writeback_is_vector_i;
                writeback_value_o     <= ng_value;
                mask_o                <= ng_mask;
            end
        end
    end

    assign gather_busy_o = (state == COLLECT);

endmodule
